multicycle_control: RTL
=======================

# multicycle_control

Multicycle sequencer for the RV32I datapath. It replaces the single-cycle opcode decode with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It time-shares one ALU and one unified memory port across those phases. It sits beside the datapath, consumes the opcode, the ALU zero flag and a memory ready handshake, and drives every datapath enable and mux select.

## Interface
- WAIT_LIMIT, 15, max cycles a memory access may wait with ready low before bus-error trap; 0 disables timeout
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  synchronous, active-low reset
- i_OPCode  input  7  instruction register bits [6:0]
- i_Zero  input  1  ALU zero flag (rs1 == rs2 on subtract)
- i_MemReady  input  1  memory completes current read/write this cycle
- o_PCWrite  output  1  load PC
- o_OldPCWrite  output  1  capture fetch PC into old-PC register
- o_IRWrite  output  1  load instruction register
- o_IorD  output  1  memory address select: 0=PC, 1=ALUOut
- o_MemRead, o_MemWrite  output  1  memory request strobes, held until i_MemReady
- o_MemToReg  output  1  write-back select: 0=ALUOut, 1=MDR
- o_RegWrite  output  1  register file write enable
- o_ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1
- o_ALUSrcB  output  2  00=rs2, 01=constant 4, 10=immediate
- o_ALUOp  output  2  00=add, 01=subtract, 10=R funct, 11=I funct
- o_PCSource  output  1  0=ALU result, 1=ALUOut
- o_Retire  output  1  one-cycle pulse on final cycle of each completed instruction
- o_IllegalOp  output  1  sticky trap flag, unknown opcode
- o_BusError  output  1  sticky trap flag, memory timeout
- o_State  output  4  current state encoding, for debug

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, ALU_WB, TRAP.
- FETCH
  - Drives MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - When i_MemReady=1, pulses IRWrite, OldPCWrite and PCWrite in the same cycle, then goes to DECODE.
  - Otherwise stays in FETCH.
- DECODE
  - Computes the branch target into ALUOut with ALUSrcA=01, ALUSrcB=10, ALUOp=00.
  - Opcode dispatch: 0110011→EXEC_R; 0010011→EXEC_I; 0000011 and 0100011→ADDR; 1100011→BRANCH; any other opcode→TRAP with IllegalOp set.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALU_WB.
- EXEC_I: ALUSrcA=10, ALUSrcB=10, ALUOp=11, then ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0, Retire=1, then FETCH.
- ADDR: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: MemRead=1, IorD=1. Waits for ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, Retire=1, then FETCH.
- MEM_WR: MemWrite=1, IorD=1. Waits for ready; on ready asserts Retire=1 and goes to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=i_Zero, Retire=1, then FETCH.
- TRAP: absorbing state with all enables 0. Only reset leaves it.
- Wait counter
  - Width $clog2(WAIT_LIMIT+1).
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states while i_MemReady=0.
  - If the count equals WAIT_LIMIT and i_MemReady=0, next state is TRAP and BusError is set.
  - If ready arrives in the same cycle the limit is hit, ready wins and the access completes.
- Every output not listed for a state is 0.

## Timing
- Reset: while i_rst_n=0 at a clock edge, state←FETCH, counter←0, IllegalOp←0, BusError←0. All outputs are 0 while reset is asserted. Reset in any state, including mid-access, aborts the instruction with no register or memory write.
- Output types:
  - State outputs are Moore decodes of the registered state.
  - PCWrite, IRWrite and OldPCWrite in FETCH, Retire in MEM_WR, and PCWrite in BRANCH are Mealy on i_MemReady / i_Zero.
- Latency with zero-wait memory: branch 3 cycles, R/I 4, store 4, load 5. Each wait cycle adds 1.
- Handshake: MemRead/MemWrite stay high from the first cycle of the state until and including the ready cycle. No request is issued in the cycle after ready unless the next state itself requests.

## Structure
- Shared package rv_ctrl_pkg holds: opcode constants, state encoding localparams, ALUOp encodings, ALUSrcA/ALUSrcB select encodings.
- Sub-module mem_wait_timer holds the wait counter: clear, count enable, WAIT_LIMIT compare, timeout output.

## Test plan
- ADD (0110011), ready always 1 → states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite high in cycle 4 only; Retire pulse in cycle 4.
- LW (0000011), ready low 3 cycles in MEM_RD → MemRead held 4 cycles with IorD=1; MEM_WB has MemToReg=1; total 8 cycles.
- BEQ with i_Zero=1 then i_Zero=0 → PCWrite=1, PCSource=1 in BRANCH for the first case; PCWrite=0 for the second; both take 3 cycles.
- Opcode 1111111 → TRAP after DECODE; IllegalOp=1 holds for 10+ cycles; i_rst_n low one edge → FETCH with IllegalOp=0.
- WAIT_LIMIT=15, ready never asserted in FETCH → TRAP on the 16th cycle with BusError=1; ready asserted exactly on cycle 16 → DECODE instead.
- Reset asserted mid MEM_WR wait → next cycle FETCH, MemWrite=0, no Retire.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle sequencer: opcodes, FSM states,
// ALU operation codes and ALU operand selects.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Values are visible on o_State, so they are pinned explicitly.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WB = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_ALU_WB = 4'd9,
    S_TRAP   = 4'd10
  } state_e;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access has waited with ready low and flags a timeout
// when the count reaches WAIT_LIMIT without ready. WAIT_LIMIT=0 disables it.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_count_en && !i_ready && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Ready in the same cycle as the limit suppresses the timeout.
  assign o_timeout = (WAIT_LIMIT != 0) && i_count_en && !i_ready && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, driving all datapath enables and selects.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_OPCode,
  input  logic       i_Zero,
  input  logic       i_MemReady,
  output logic       o_PCWrite,
  output logic       o_OldPCWrite,
  output logic       o_IRWrite,
  output logic       o_IorD,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_MemToReg,
  output logic       o_RegWrite,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ALUOp,
  output logic       o_PCSource,
  output logic       o_Retire,
  output logic       o_IllegalOp,
  output logic       o_BusError,
  output logic [3:0] o_State
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       timeout;
  logic       wait_state;

  logic       pc_write, old_pc_write, ir_write, iord, mem_read, mem_write;
  logic       mem_to_reg, reg_write, pc_source, retire;
  logic [1:0] alu_src_a, alu_src_b, alu_op;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Any state change restarts the count, so every wait state is entered at zero.
  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (state_d != state_q),
    .i_count_en (wait_state),
    .i_ready    (i_MemReady),
    .o_timeout  (timeout)
  );

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    pc_write     = 1'b0;
    old_pc_write = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    pc_source    = 1'b0;
    retire       = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else if (i_MemReady) begin
          pc_write     = 1'b1;
          old_pc_write = 1'b1;
          ir_write     = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (i_OPCode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_RFUNCT;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_IFUNCT;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (i_OPCode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else if (i_MemReady) begin
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else if (i_MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_source = 1'b1;
        pc_write  = i_Zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Everything is forced low during reset so an aborted access writes nothing.
  assign o_PCWrite    = i_rst_n & pc_write;
  assign o_OldPCWrite = i_rst_n & old_pc_write;
  assign o_IRWrite    = i_rst_n & ir_write;
  assign o_IorD       = i_rst_n & iord;
  assign o_MemRead    = i_rst_n & mem_read;
  assign o_MemWrite   = i_rst_n & mem_write;
  assign o_MemToReg   = i_rst_n & mem_to_reg;
  assign o_RegWrite   = i_rst_n & reg_write;
  assign o_ALUSrcA    = {2{i_rst_n}} & alu_src_a;
  assign o_ALUSrcB    = {2{i_rst_n}} & alu_src_b;
  assign o_ALUOp      = {2{i_rst_n}} & alu_op;
  assign o_PCSource   = i_rst_n & pc_source;
  assign o_Retire     = i_rst_n & retire;
  assign o_IllegalOp  = i_rst_n & illegal_q;
  assign o_BusError   = i_rst_n & bus_err_q;
  assign o_State      = i_rst_n ? state_q : 4'd0;

endmodule
